// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state encodings and the fetch PC step for the instruction-fetch unit
package ifu_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;
  localparam int INST_STEP = 4;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush, occupancy count, and push+pop in the same cycle even when full
module ifu_fifo #(
  parameter int W = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rp];
  // storage has no reset; only the pointers and count define validity
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointer and occupancy bookkeeping; flush empties the queue in one cycle
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: single-outstanding instruction prefetcher with redirect flush; IFU_MISALIGN_CHECK_EN adds misaligned-redirect fault + HALT
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst_data,
  output logic            inst_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            fault;
  } entry_t;
  entry_t push_entry, head;
  logic [2:0] state, state_n;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [CW-1:0] count;
  logic stale, fault_pend, fault_push, hs, push, pop, empty, can_req, room_after;
  assign hs = mem_req_valid && mem_req_ready;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  assign push = (state == S_WAIT && mem_rsp_valid && !redirect_valid) || fault_push;
  assign can_req = count < CW'(DEPTH) && !fault_pend;
  assign room_after = pop || count < CW'(DEPTH - 1);
  assign push_entry = fault_push ? '{pc: fetch_pc, inst: '0, fault: 1'b1}
                                 : '{pc: req_pc, inst: mem_rsp_data, fault: 1'b0};
  assign mem_req_valid = state == S_REQ;
  assign mem_req_addr = req_pc;
  assign inst_valid = !empty;
  assign inst_pc = head.pc;
  assign inst_data = head.inst;
  assign inst_fault = !empty && head.fault;
`ifdef IFU_MISALIGN_CHECK_EN
  assign fault_push = state == S_IDLE && fault_pend && !redirect_valid;
  // a misaligned redirect arms a fault entry that is queued once nothing is in flight
  always_ff @(posedge clk)
    if (rst) fault_pend <= 1'b0;
    else fault_pend <= redirect_valid ? redirect_pc[1:0] != 2'b00 : fault_pend && !fault_push;
`else
  assign fault_push = 1'b0;
  assign fault_pend = 1'b0;
`endif
  ifu_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .din(push_entry),
    .pop(pop),
    .dout(head),
    .count(count),
    .empty(empty)
  );
  // fetch FSM: redirect beats everything; stale requests and responses drain through DROP
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = redirect_valid ? S_IDLE : fault_push ? S_HALT : can_req ? S_REQ : S_IDLE;
      S_REQ:  state_n = !hs ? S_REQ : (stale || redirect_valid) ? S_DROP : S_WAIT;
      S_WAIT: state_n = !mem_rsp_valid ? (redirect_valid ? S_DROP : S_WAIT)
                                       : (!redirect_valid && room_after) ? S_REQ : S_IDLE;
      S_DROP: state_n = !mem_rsp_valid ? S_DROP : (!redirect_valid && can_req) ? S_REQ : S_IDLE;
      S_HALT: state_n = redirect_valid ? S_IDLE : S_HALT;
      default: state_n = S_IDLE;
    endcase
  end
  // PC tracking: req_pc is frozen on entry to REQ so the address stays stable until accepted
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      stale <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= redirect_valid ? redirect_pc : (hs && !stale) ? fetch_pc + XLEN'(INST_STEP) : fetch_pc;
      if (state_n == S_REQ && state != S_REQ) req_pc <= fetch_pc;
      stale <= state == S_REQ && !hs && (stale || redirect_valid);
    end
endmodule
